// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } muldiv_state_e;

    // func3 encodings of the M-extension ops
    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;
    localparam logic [2:0] DIV_F3    = 3'b100;
    localparam logic [2:0] DIVU_F3   = 3'b101;
    localparam logic [2:0] REM_F3    = 3'b110;
    localparam logic [2:0] REMU_F3   = 3'b111;

    // Quotient returned on divide by zero
    localparam logic [XLEN-1:0] DIV_ZERO_Q          = '1;
    // Most negative dividend; with a divisor of -1 the signed quotient overflows
    localparam logic [XLEN-1:0] SIGNED_OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] SIGNED_OVF_DIVISOR  = '1;

    function automatic logic op_a_signed(logic [2:0] f3);
        return f3 inside {MULH_F3, MULHSU_F3, DIV_F3, REM_F3};
    endfunction

    function automatic logic op_b_signed(logic [2:0] f3);
        return f3 inside {MULH_F3, DIV_F3, REM_F3};
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the mul/div sequencer.
interface muldiv_seq_if;
    import muldiv_pkg::*;

    logic            start_i;
    logic [2:0]      func3_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    // Execute-stage side: issues requests, observes stall and result
    modport master (
        output start_i, func3_i, op_a_i, op_b_i, flush_i,
        input  busy_o, done_o, result_o
    );

    // Sequencer side
    modport slave (
        input  start_i, func3_i, op_a_i, op_b_i, flush_i,
        output busy_o, done_o, result_o
    );

endinterface

// File: rtl/muldiv_datapath.sv
// Radix-2 multiply/divide datapath: shared 2*XLEN+1 accumulator, operand
// conditioning at load, one shift/add or shift/subtract per step, and sign
// and special-case correction on finish.
module muldiv_datapath
    import muldiv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            finish_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned AccW = 2 * XLEN + 1;

    logic [AccW-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mag_b_q;
    logic [XLEN-1:0] op_a_q;
    logic [2:0]      func3_q;
    logic            neg_res_q;
    logic            neg_rem_q;
    logic            b_zero_q;
    logic            ovf_q;
    logic [XLEN-1:0] result_q, result_d;

    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            ovf;

    // Operand conditioning: sign flags and magnitudes of the incoming request
    always_comb begin
        sign_a = op_a_i[XLEN-1] & op_a_signed(func3_i);
        sign_b = op_b_i[XLEN-1] & op_b_signed(func3_i);
        mag_a  = sign_a ? -op_a_i : op_a_i;
        mag_b  = sign_b ? -op_b_i : op_b_i;
        ovf    = ((func3_i == DIV_F3) || (func3_i == REM_F3)) &&
                 (op_a_i == SIGNED_OVF_DIVIDEND) && (op_b_i == SIGNED_OVF_DIVISOR);
    end

    logic [XLEN:0]   mul_sum;
    logic [XLEN+1:0] div_diff;

    // One iteration: multiply shifts right after a conditional add, divide
    // shifts left and keeps the trial subtract unless it borrowed
    always_comb begin
        mul_sum  = acc_q[AccW-1:XLEN] + {1'b0, (acc_q[0] ? mag_b_q : {XLEN{1'b0}})};
        // acc_q[AccW-1:XLEN-1] is the left-shifted partial remainder, guard bit included
        div_diff = acc_q[AccW-1:XLEN-1] - {2'b00, mag_b_q};
        if (func3_q[2]) begin
            if (div_diff[XLEN+1]) begin
                acc_d = {acc_q[AccW-2:0], 1'b0};
            end else begin
                acc_d = {div_diff[XLEN:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_d = {1'b0, mul_sum, acc_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    // Final result selection with sign correction and special cases
    always_comb begin
        prod     = acc_q[2*XLEN-1:0];
        prod_fix = neg_res_q ? -prod : prod;
        quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        result_d = result_q;
        case (func3_q)
            MUL_F3: begin
                result_d = prod_fix[XLEN-1:0];
            end
            MULH_F3, MULHSU_F3, MULHU_F3: begin
                result_d = prod_fix[2*XLEN-1:XLEN];
            end
            DIV_F3, DIVU_F3: begin
                if (b_zero_q) begin
                    result_d = DIV_ZERO_Q;
                end else if (ovf_q) begin
                    result_d = SIGNED_OVF_DIVIDEND;
                end else begin
                    result_d = quo_fix;
                end
            end
            default: begin
                if (b_zero_q) begin
                    result_d = op_a_q;
                end else if (ovf_q) begin
                    result_d = '0;
                end else begin
                    result_d = rem_fix;
                end
            end
        endcase
    end

    // Operand latch and accumulator update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q     <= '0;
            mag_b_q   <= '0;
            op_a_q    <= '0;
            func3_q   <= MUL_F3;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (load_i) begin
            // Both multiply and divide start with |op_a| in the low half
            acc_q     <= {{(XLEN+1){1'b0}}, mag_a};
            mag_b_q   <= mag_b;
            op_a_q    <= op_a_i;
            func3_q   <= func3_i;
            neg_res_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            b_zero_q  <= (op_b_i == '0);
            ovf_q     <= ovf;
        end else if (step_i) begin
            acc_q     <= acc_d;
        end
    end

    // Result register, only written on the finishing edge so flush keeps it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= '0;
        end else if (finish_i) begin
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: IDLE/BUSY/DONE control around
// muldiv_datapath, fixed XLEN+1 cycle latency, flush aborts without done.
module muldiv_seq
    import muldiv_pkg::*;
(
    input logic         clk_i,
    input logic         rst_i,
    muldiv_seq_if.slave bus
);

    muldiv_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            last_q;
    logic            load, step, finish;
    logic            busy, done;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Iteration counter; last_q marks that all XLEN steps are done and the
    // next BUSY cycle is the correction/finish cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else if (load) begin
            cnt_q  <= CntW'(XLEN - 1);
            last_q <= 1'b0;
        end else if (step) begin
            if (cnt_q == '0) begin
                last_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Next-state logic; flush wins over everything
    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (bus.start_i) state_d = StBusy;
                StBusy:  if (last_q) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath strobes and status outputs
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        busy   = (state_q != StIdle);
        done   = (state_q == StDone);
        if (!bus.flush_i) begin
            load   = (state_q == StIdle) && bus.start_i;
            step   = (state_q == StBusy) && !last_q;
            finish = (state_q == StBusy) && last_q;
        end
    end

    muldiv_datapath u_datapath (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load),
        .step_i   (step),
        .finish_i (finish),
        .func3_i  (bus.func3_i),
        .op_a_i   (bus.op_a_i),
        .op_b_i   (bus.op_b_i),
        .result_o (bus.result_o)
    );

    assign bus.busy_o = busy;
    assign bus.done_o = done;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_seq_if bus_if ();

    muldiv_seq dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference: RV32M semantics via 64-bit arithmetic
    function automatic logic [31:0] ref_model(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        longint      sa, sb, q;
        logic [63:0] ua, ub, p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin q = sa / sb; r = q[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else begin q = sa % sb; r = q[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op from IDLE and wait (bounded) for done; leaves the DUT in IDLE
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit busy_ok);
        bus_if.start_i = 1'b1;
        bus_if.func3_i = f3;
        bus_if.op_a_i  = a;
        bus_if.op_b_i  = b;
        @(posedge clk); #1;
        bus_if.start_i = 1'b0;
        busy_ok = bus_if.busy_o;
        lat     = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (bus_if.done_o) begin
                lat = i;
                break;
            end
            if (!bus_if.busy_o) busy_ok = 1'b0;
        end
        res = bus_if.result_o;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus_if.start_i = 1'b0;
        bus_if.flush_i = 1'b0;
        bus_if.func3_i = '0;
        bus_if.op_a_i  = '0;
        bus_if.op_b_i  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (bus_if.busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", bus_if.busy_o);
        else n_pass++;
        n_total++;
        if (bus_if.done_o !== 1'b0) $display("FAIL reset_done got %b want 0", bus_if.done_o);
        else n_pass++;
        n_total++;
        if (bus_if.result_o !== 32'h0) $display("FAIL reset_result got %h want 0", bus_if.result_o);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [10] = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd6, 3'd7, 3'd5, 3'd4, 3'd6, 3'd1};
        logic [31:0] as  [10] = '{32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                  32'hFFFF_FFF9, 32'h7, 32'h7, 32'h8000_0000,
                                  32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs  [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2, 32'h2,
                                  32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [10] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                  32'hFFFF_FFFF, 32'h7, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h0, 32'h0};
        logic [31:0] res;
        int          lat;
        bit          bok;
        for (int i = 0; i < 10; i++) begin
            run_op(f3s[i], as[i], bs[i], res, lat, bok);
            n_total++;
            if (res !== exp[i]) $display("FAIL directed_%0d result got %h want %h", i, res, exp[i]);
            else n_pass++;
            n_total++;
            if (lat !== 33) $display("FAIL directed_%0d latency got %0d want 33", i, lat);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res, exp;
        int          lat;
        bit          bok;
        for (int i = 0; i < 30; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            exp = ref_model(f3, a, b);
            run_op(f3, a, b, res, lat, bok);
            n_total++;
            if (res !== exp)
                $display("FAIL random_%0d f3=%0d a=%h b=%h got %h want %h", i, f3, a, b, res, exp);
            else n_pass++;
            n_total++;
            if (lat !== 33 || !bok) $display("FAIL random_%0d timing lat %0d busy %b want 33/1",
                                             i, lat, bok);
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] a, b, exp, res;
        int          lat;
        a   = $urandom;
        b   = $urandom | 32'h1;
        exp = ref_model(DIVU_F3, a, b);
        bus_if.start_i = 1'b1;
        bus_if.func3_i = DIVU_F3;
        bus_if.op_a_i  = a;
        bus_if.op_b_i  = b;
        @(posedge clk); #1;
        bus_if.start_i = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            // Second request mid-BUSY with different operands
            if (i == 10) begin
                bus_if.start_i = 1'b1;
                bus_if.func3_i = MUL_F3;
                bus_if.op_a_i  = ~a;
                bus_if.op_b_i  = 32'h3;
            end else begin
                bus_if.start_i = 1'b0;
            end
            @(posedge clk); #1;
            if (bus_if.done_o) begin
                lat = i;
                break;
            end
        end
        bus_if.start_i = 1'b0;
        res = bus_if.result_o;
        @(posedge clk); #1;
        n_total++;
        if (res !== exp) $display("FAIL start_ignored result got %h want %h", res, exp);
        else n_pass++;
        n_total++;
        if (lat !== 33) $display("FAIL start_ignored latency got %0d want 33", lat);
        else n_pass++;
        n_total++;
        if (bus_if.busy_o !== 1'b0) $display("FAIL start_ignored no_requeue busy got %b want 0",
                                             bus_if.busy_o);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [31:0] prev, res;
        int          lat;
        bit          bok;
        bit          seen_done;
        run_op(MULHU_F3, 32'h1234_5678, 32'h9ABC_DEF0, prev, lat, bok);
        n_total++;
        if (prev !== 32'h0B00_EA4E) $display("FAIL flush_setup got %h want 0b00ea4e", prev);
        else n_pass++;
        bus_if.start_i = 1'b1;
        bus_if.func3_i = DIV_F3;
        bus_if.op_a_i  = $urandom;
        bus_if.op_b_i  = 32'h5;
        @(posedge clk); #1;
        bus_if.start_i = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        bus_if.flush_i = 1'b1;
        @(posedge clk); #1;
        bus_if.flush_i = 1'b0;
        n_total++;
        if (bus_if.busy_o !== 1'b0) $display("FAIL flush_busy got %b want 0", bus_if.busy_o);
        else n_pass++;
        n_total++;
        if (bus_if.result_o !== prev) $display("FAIL flush_result got %h want %h",
                                               bus_if.result_o, prev);
        else n_pass++;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus_if.done_o) seen_done = 1'b1;
        end
        n_total++;
        if (seen_done !== 1'b0) $display("FAIL flush_no_done got %b want 0", seen_done);
        else n_pass++;
        n_total++;
        if (bus_if.result_o !== prev) $display("FAIL flush_hold got %h want %h",
                                               bus_if.result_o, prev);
        else n_pass++;
        // Flush and start together in IDLE: flush wins
        bus_if.start_i = 1'b1;
        bus_if.flush_i = 1'b1;
        @(posedge clk); #1;
        bus_if.start_i = 1'b0;
        bus_if.flush_i = 1'b0;
        n_total++;
        if (bus_if.busy_o !== 1'b0) $display("FAIL flush_priority busy got %b want 0",
                                             bus_if.busy_o);
        else n_pass++;
        run_op(REM_F3, 32'hFFFF_FFF9, 32'h2, res, lat, bok);
        n_total++;
        if (res !== 32'hFFFF_FFFF || lat !== 33)
            $display("FAIL flush_recover got %h/%0d want ffffffff/33", res, lat);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b, res, exp;
        int          lat;
        bit          bok;
        bus_if.start_i = 1'b1;
        bus_if.func3_i = MULH_F3;
        bus_if.op_a_i  = $urandom;
        bus_if.op_b_i  = $urandom;
        @(posedge clk); #1;
        bus_if.start_i = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++;
        if (bus_if.busy_o !== 1'b0 || bus_if.done_o !== 1'b0 || bus_if.result_o !== 32'h0)
            $display("FAIL reset_mid outputs got busy %b done %b result %h want 0/0/0",
                     bus_if.busy_o, bus_if.done_o, bus_if.result_o);
        else n_pass++;
        a   = $urandom;
        b   = $urandom;
        exp = ref_model(MULHSU_F3, a, b);
        run_op(MULHSU_F3, a, b, res, lat, bok);
        n_total++;
        if (res !== exp || lat !== 33)
            $display("FAIL reset_mid_restart got %h/%0d want %h/33", res, lat, exp);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3;
        logic [31:0] a, b, res, exp;
        int          lat;
        bit          bok;
        for (int i = 0; i < 4; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            exp = ref_model(f3, a, b);
            run_op(f3, a, b, res, lat, bok);
            n_total++;
            if (res !== exp || lat !== 33)
                $display("FAIL b2b_%0d got %h/%0d want %h/33", i, res, lat, exp);
            else n_pass++;
            // One cycle after done: back in IDLE, pulse over
            n_total++;
            if (bus_if.busy_o !== 1'b0 || bus_if.done_o !== 1'b0)
                $display("FAIL b2b_%0d idle got busy %b done %b want 0/0", i,
                         bus_if.busy_o, bus_if.done_o);
            else n_pass++;
            n_total++;
            if (bus_if.result_o !== exp)
                $display("FAIL b2b_%0d hold got %h want %h", i, bus_if.result_o, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
